// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - input/output handshake bundle for the immediate extender
// The extender sits on the slave side; the producer/consumer on the master side.
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       mode_i;
  logic [IN_W-1:0]  data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] data_o;

  modport slave (
    input  in_valid_i, mode_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o
  );

  modport master (
    output in_valid_i, mode_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender feeding a 2-entry output FIFO
// Extension is computed at acceptance; data_o is the FIFO head entry.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  imm_extend_pipe_if.slave  bus
);

  generate
    if (OUT_W < IN_W + SHAMT) begin : g_bad_params
      $error("imm_extend_pipe: OUT_W must be at least IN_W+SHAMT");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [OUT_W-1:0] mem_q [2];
  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] sext;
  logic             accept;
  logic             consume;

  always_comb begin
    sext  = OUT_W'($signed(bus.data_i));
    ext_d = '0;
    case (bus.mode_i)
      2'b00:   ext_d = sext;
      2'b01:   ext_d = OUT_W'(bus.data_i);
      2'b10:   ext_d = OUT_W'(bus.data_i) << (OUT_W - IN_W);
      default: ext_d = sext << SHAMT;
    endcase
  end

  assign accept  = bus.in_valid_i && in_ready_q && !flush_i;
  assign consume = out_valid_q && bus.out_ready_i && !flush_i;

  // Reset outranks flush, which outranks any accept/consume in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= ext_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (consume) rd_ptr_q <= ~rd_ptr_q;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !consume) begin
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (!accept && consume) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (consume) begin
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.data_o      = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;

  logic clk;
  logic rst;
  logic flush;
  int   n_checks;
  int   n_pass;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [1:0] mode, input logic [15:0] data,
                          input logic [31:0] exp, input string tag);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.mode_i      = mode;
    bus.data_i      = data;
    step();
    check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
    check({tag, "_data"}, bus.data_o, exp);
    bus.in_valid_i = 1'b0;
    step();
    check({tag, "_drained"}, 32'(bus.out_valid_o), 32'd0);
  endtask

  task automatic push_held(input logic [15:0] data);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.mode_i      = 2'b01;
    bus.data_i      = data;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.mode_i      = 2'b00;
    bus.data_i      = 16'h1234;
    bus.out_ready_i = 1'b0;
    step();
    step();
    rst            = 1'b0;
    bus.in_valid_i = 1'b0;
    check("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("rst_data", bus.data_o, 32'h0);
    check("rst_ready", 32'(bus.in_ready_o), 32'd1);

    send_one(2'b00, 16'h8000, 32'hFFFF8000, "sx_neg");
    send_one(2'b00, 16'h7FFF, 32'h00007FFF, "sx_pos");
    send_one(2'b01, 16'h8000, 32'h00008000, "zx");
    send_one(2'b10, 16'h1234, 32'h12340000, "upper");
    send_one(2'b11, 16'hFFFF, 32'hFFFFFFFC, "sshift_neg");
    send_one(2'b11, 16'h4001, 32'h00010004, "sshift_pos");

    push_held(16'h0001);
    push_held(16'h0002);
    check("bp_full_ready", 32'(bus.in_ready_o), 32'd0);
    push_held(16'h0003);
    check("bp_still_full", 32'(bus.in_ready_o), 32'd0);
    check("bp_hold_valid", 32'(bus.out_valid_o), 32'd1);
    check("bp_hold_data", bus.data_o, 32'h1);
    bus.out_ready_i = 1'b1;
    step();
    check("bp_out2", bus.data_o, 32'h2);
    step();
    check("bp_out3", bus.data_o, 32'h3);
    bus.in_valid_i = 1'b0;
    step();
    check("bp_empty", 32'(bus.out_valid_o), 32'd0);

    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.mode_i      = 2'b01;
    bus.data_i      = 16'h0010;
    step();
    for (int k = 1; k <= 4; k++) begin
      bus.data_i = 16'(16'h0010 + k);
      step();
      check($sformatf("stream_data%0d", k), bus.data_o, 32'(32'h10 + k));
      check($sformatf("stream_ready%0d", k), 32'(bus.in_ready_o), 32'd1);
    end
    bus.in_valid_i = 1'b0;
    step();
    check("stream_empty", 32'(bus.out_valid_o), 32'd0);

    push_held(16'h00A1);
    push_held(16'h00A2);
    check("fl_full", 32'(bus.in_ready_o), 32'd0);
    flush          = 1'b1;
    bus.data_i     = 16'h00A3;
    step();
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    check("fl_valid", 32'(bus.out_valid_o), 32'd0);
    check("fl_ready", 32'(bus.in_ready_o), 32'd1);
    send_one(2'b01, 16'h0055, 32'h00000055, "fl_after");

    push_held(16'h000B);
    push_held(16'h000C);
    rst            = 1'b1;
    bus.in_valid_i = 1'b0;
    step();
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    check("mid_rst_data", bus.data_o, 32'h0);
    check("mid_rst_ready", 32'(bus.in_ready_o), 32'd1);
    send_one(2'b00, 16'h8000, 32'hFFFF8000, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
